// File: rtl/id_pkg.sv
// Shared constants for the ID stage: instruction field positions, forwarding
// source encoding and the register-address width helper.
package id_pkg;

   localparam int unsigned INST_W = 32;
   localparam int unsigned IMM_W  = 16;
   localparam int unsigned RS_LSB = 21;
   localparam int unsigned RT_LSB = 16;
   localparam int unsigned RD_LSB = 11;

   typedef enum logic [1:0] {
      FWD_RF  = 2'd0,
      FWD_EXE = 2'd1,
      FWD_MEM = 2'd2,
      FWD_WB  = 2'd3
   } fwd_sel_e;

   // ceil(log2(n)), minimum 1
   function automatic int unsigned calc_aw(input int unsigned n);
      int unsigned w;
      w = 1;
      for (int unsigned i = 1; i < 32; i++) begin
         if ((64'd1 << i) < 64'(n)) w = i + 1;
      end
      return w;
   endfunction

endpackage

// File: rtl/id_stage_if.sv
// IF->ID->EXE bus of the decode stage, including the forwarding taps from
// later stages. slave = the ID stage, master = the surrounding pipeline.
interface id_stage_if import id_pkg::*; #(
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned REG_NUM = 32,
   parameter int unsigned CTL_W   = 24
) ();
   localparam int unsigned AW = calc_aw(REG_NUM);

   logic                in_valid;
   logic                in_ready;
   logic [INST_W-1:0]   i_inst;
   logic [31:0]         i_pc;
   logic [CTL_W-1:0]    i_ctl;
   logic                i_sext;
   logic                i_rd_or_rt;
   logic                i_use_rs;
   logic                i_use_rt;

   logic                exe_wen;
   logic                exe_is_load;
   logic [AW-1:0]       exe_wreg;
   logic [DATA_W-1:0]   exe_wdata;
   logic                mem_wen;
   logic [AW-1:0]       mem_wreg;
   logic [DATA_W-1:0]   mem_wdata;
   logic                wb_wen;
   logic [AW-1:0]       wb_waddr;
   logic [DATA_W-1:0]   wb_wdata;
   logic                flush;

   logic                rs_eq_rt;
   logic [DATA_W-1:0]   jrpc;

   logic                out_valid;
   logic                out_ready;
   logic [31:0]         o_pc;
   logic [DATA_W-1:0]   o_da;
   logic [DATA_W-1:0]   o_db;
   logic [DATA_W-1:0]   o_imm;
   logic [AW-1:0]       o_rn;
   logic [CTL_W-1:0]    o_ctl;

   modport slave (
      input  in_valid, i_inst, i_pc, i_ctl, i_sext, i_rd_or_rt, i_use_rs, i_use_rt,
      input  exe_wen, exe_is_load, exe_wreg, exe_wdata,
      input  mem_wen, mem_wreg, mem_wdata, wb_wen, wb_waddr, wb_wdata,
      input  flush, out_ready,
      output in_ready, rs_eq_rt, jrpc,
      output out_valid, o_pc, o_da, o_db, o_imm, o_rn, o_ctl
   );

   modport master (
      output in_valid, i_inst, i_pc, i_ctl, i_sext, i_rd_or_rt, i_use_rs, i_use_rt,
      output exe_wen, exe_is_load, exe_wreg, exe_wdata,
      output mem_wen, mem_wreg, mem_wdata, wb_wen, wb_waddr, wb_wdata,
      output flush, out_ready,
      input  in_ready, rs_eq_rt, jrpc,
      input  out_valid, o_pc, o_da, o_db, o_imm, o_rn, o_ctl
   );

endinterface

// File: rtl/id_regfile.sv
// Architectural register file: two combinational read ports, one write port,
// r0 hardwired to zero, same-cycle write-through to both read ports.
module id_regfile import id_pkg::*; #(
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned REG_NUM = 32
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic [calc_aw(REG_NUM)-1:0]    i_ra,
   input  logic [calc_aw(REG_NUM)-1:0]    i_rb,
   input  logic                           i_wen,
   input  logic [calc_aw(REG_NUM)-1:0]    i_waddr,
   input  logic [DATA_W-1:0]              i_wdata,
   output logic [DATA_W-1:0]              o_rda_c,
   output logic [DATA_W-1:0]              o_rdb_c
);
   logic [DATA_W-1:0] r_mem [REG_NUM];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < REG_NUM; i++) r_mem[i] <= '0;
      end else if (i_wen && (i_waddr != '0)) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   assign o_rda_c = (i_ra == '0) ? '0 :
                    (i_wen && (i_waddr == i_ra)) ? i_wdata : r_mem[i_ra];
   assign o_rdb_c = (i_rb == '0) ? '0 :
                    (i_wen && (i_waddr == i_rb)) ? i_wdata : r_mem[i_rb];

endmodule

// File: rtl/id_stage.sv
// MIPS instruction-decode stage: regfile, EXE/MEM/WB forwarding, load-use stall,
// branch compare and ID/EX register. Define ID_STAGE_STALL_CNT_EN for stall_cnt.
module id_stage import id_pkg::*; #(
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned REG_NUM = 32,
   parameter int unsigned CTL_W   = 24
) (
   input  logic         clk,
   input  logic         reset,
   id_stage_if.slave    bus
`ifdef ID_STAGE_STALL_CNT_EN
   ,
   output logic [31:0]  stall_cnt
`endif
);
   localparam int unsigned AW        = calc_aw(REG_NUM);
   localparam int unsigned IMM_EXT_W = DATA_W - IMM_W;

   logic [AW-1:0]     w_rs, w_rt, w_rn;
   logic [DATA_W-1:0] w_rf_a, w_rf_b, w_da, w_db, w_imm;
   logic              w_exe_fwd_en, w_stall, w_in_ready, w_fire;
   fwd_sel_e          w_sel_a, w_sel_b;

   logic              r_out_valid;
   logic [31:0]       r_pc;
   logic [DATA_W-1:0] r_da, r_db, r_imm;
   logic [AW-1:0]     r_rn;
   logic [CTL_W-1:0]  r_ctl;

   // Youngest matching producer wins; r0 and loads in EXE never forward.
   function automatic fwd_sel_e fwd_pick(input logic [AW-1:0] r,
                                         input logic e_en, input logic [AW-1:0] e_w,
                                         input logic m_en, input logic [AW-1:0] m_w,
                                         input logic b_en, input logic [AW-1:0] b_w);
      if (r == '0)              return FWD_RF;
      if (e_en && (e_w == r))   return FWD_EXE;
      if (m_en && (m_w == r))   return FWD_MEM;
      if (b_en && (b_w == r))   return FWD_WB;
      return FWD_RF;
   endfunction

   function automatic logic [DATA_W-1:0] fwd_mux(input fwd_sel_e s,
                                                 input logic [DATA_W-1:0] rf,
                                                 input logic [DATA_W-1:0] e,
                                                 input logic [DATA_W-1:0] m,
                                                 input logic [DATA_W-1:0] b);
      case (s)
         FWD_EXE: return e;
         FWD_MEM: return m;
         FWD_WB:  return b;
         default: return rf;
      endcase
   endfunction

   assign w_rs = bus.i_inst[RS_LSB +: AW];
   assign w_rt = bus.i_inst[RT_LSB +: AW];
   assign w_rn = bus.i_rd_or_rt ? bus.i_inst[RD_LSB +: AW] : w_rt;

   id_regfile #(.DATA_W(DATA_W), .REG_NUM(REG_NUM)) u_regfile (
      .clk     (clk),
      .reset   (reset),
      .i_ra    (w_rs),
      .i_rb    (w_rt),
      .i_wen   (bus.wb_wen),
      .i_waddr (bus.wb_waddr),
      .i_wdata (bus.wb_wdata),
      .o_rda_c (w_rf_a),
      .o_rdb_c (w_rf_b)
   );

   assign w_exe_fwd_en = bus.exe_wen & ~bus.exe_is_load;
   assign w_sel_a = fwd_pick(w_rs, w_exe_fwd_en, bus.exe_wreg, bus.mem_wen, bus.mem_wreg,
                             bus.wb_wen, bus.wb_waddr);
   assign w_sel_b = fwd_pick(w_rt, w_exe_fwd_en, bus.exe_wreg, bus.mem_wen, bus.mem_wreg,
                             bus.wb_wen, bus.wb_waddr);
   assign w_da = fwd_mux(w_sel_a, w_rf_a, bus.exe_wdata, bus.mem_wdata, bus.wb_wdata);
   assign w_db = fwd_mux(w_sel_b, w_rf_b, bus.exe_wdata, bus.mem_wdata, bus.wb_wdata);

   assign w_imm = bus.i_sext ? {{IMM_EXT_W{bus.i_inst[IMM_W-1]}}, bus.i_inst[IMM_W-1:0]}
                             : {{IMM_EXT_W{1'b0}}, bus.i_inst[IMM_W-1:0]};

   // Load result is not available until MEM, so a dependent instruction waits a cycle.
   assign w_stall = bus.in_valid & bus.exe_wen & bus.exe_is_load & (bus.exe_wreg != '0) &
                    ((bus.i_use_rs & (w_rs == bus.exe_wreg)) |
                     (bus.i_use_rt & (w_rt == bus.exe_wreg)));
   assign w_in_ready = bus.flush | (~w_stall & (~r_out_valid | bus.out_ready));
   assign w_fire     = bus.in_valid & w_in_ready & ~bus.flush;

   assign bus.in_ready = w_in_ready;
   assign bus.jrpc     = w_da;
   assign bus.rs_eq_rt = (w_da == w_db);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_out_valid <= 1'b0;
         r_pc        <= '0;
         r_da        <= '0;
         r_db        <= '0;
         r_imm       <= '0;
         r_rn        <= '0;
         r_ctl       <= '0;
      end else if (bus.flush) begin
         r_out_valid <= 1'b0;
      end else if (w_fire) begin
         r_out_valid <= 1'b1;
         r_pc        <= bus.i_pc;
         r_da        <= w_da;
         r_db        <= w_db;
         r_imm       <= w_imm;
         r_rn        <= w_rn;
         r_ctl       <= bus.i_ctl;
      end else if (bus.out_ready) begin
         r_out_valid <= 1'b0;
      end
   end

   assign bus.out_valid = r_out_valid;
   assign bus.o_pc      = r_pc;
   assign bus.o_da      = r_da;
   assign bus.o_db      = r_db;
   assign bus.o_imm     = r_imm;
   assign bus.o_rn      = r_rn;
   assign bus.o_ctl     = r_ctl;

`ifdef ID_STAGE_STALL_CNT_EN
   logic [31:0] r_stall_cnt;

   // Cycles where IF is held off for a reason other than a flush, saturating.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_stall_cnt <= '0;
      end else if (bus.in_valid && !w_in_ready && !bus.flush && (r_stall_cnt != '1)) begin
         r_stall_cnt <= r_stall_cnt + 32'd1;
      end
   end

   assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage: expected ID/EX payloads are queued when an
// instruction is driven and popped when the stage presents it.
module tb_id_stage;
   import id_pkg::*;

   localparam int unsigned DATA_W  = 32;
   localparam int unsigned REG_NUM = 32;
   localparam int unsigned CTL_W   = 24;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] da;
      logic [31:0] db;
      logic [31:0] imm;
      logic [4:0]  rn;
      logic [23:0] ctl;
   } exp_t;

   logic clk = 1'b0;
   logic reset;
   exp_t sb[$];
   exp_t cur;
   int   n_cmp = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   id_stage_if #(.DATA_W(DATA_W), .REG_NUM(REG_NUM), .CTL_W(CTL_W)) bus ();

`ifdef ID_STAGE_STALL_CNT_EN
   logic [31:0] stall_cnt;
`endif

   id_stage #(.DATA_W(DATA_W), .REG_NUM(REG_NUM), .CTL_W(CTL_W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
`ifdef ID_STAGE_STALL_CNT_EN
      ,
      .stall_cnt (stall_cnt)
`endif
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      bus.in_valid = 1'b0;  bus.i_inst = '0;  bus.i_pc = '0;  bus.i_ctl = '0;
      bus.i_sext = 1'b0;    bus.i_rd_or_rt = 1'b0;
      bus.i_use_rs = 1'b1;  bus.i_use_rt = 1'b1;
      bus.exe_wen = 1'b0;   bus.exe_is_load = 1'b0; bus.exe_wreg = '0; bus.exe_wdata = '0;
      bus.mem_wen = 1'b0;   bus.mem_wreg = '0;      bus.mem_wdata = '0;
      bus.wb_wen = 1'b0;    bus.wb_waddr = '0;      bus.wb_wdata = '0;
      bus.flush = 1'b0;
   endtask

   task automatic drive_inst(input logic [31:0] pc, input logic [4:0] rs, input logic [4:0] rt,
                             input logic [15:0] imm, input logic sext, input logic rdrt);
      bus.in_valid   = 1'b1;
      bus.i_inst     = {6'd0, rs, rt, imm};
      bus.i_pc       = pc;
      bus.i_ctl      = pc[23:0] ^ 24'h5A5A5A;
      bus.i_sext     = sext;
      bus.i_rd_or_rt = rdrt;
   endtask

   task automatic expect_out(input logic [31:0] pc, input logic [31:0] da, input logic [31:0] db,
                             input logic [31:0] imm, input logic [4:0] rn);
      exp_t e;
      e.pc = pc; e.da = da; e.db = db; e.imm = imm; e.rn = rn;
      e.ctl = pc[23:0] ^ 24'h5A5A5A;
      sb.push_back(e);
   endtask

   task automatic check_regs(input string tag);
      check({tag, ".o_pc"},  64'(bus.o_pc),  64'(cur.pc));
      check({tag, ".o_da"},  64'(bus.o_da),  64'(cur.da));
      check({tag, ".o_db"},  64'(bus.o_db),  64'(cur.db));
      check({tag, ".o_imm"}, 64'(bus.o_imm), 64'(cur.imm));
      check({tag, ".o_rn"},  64'(bus.o_rn),  64'(cur.rn));
      check({tag, ".o_ctl"}, 64'(bus.o_ctl), 64'(cur.ctl));
   endtask

   // One clock: sample after the edge, then return at the next falling edge.
   task automatic tick(input string tag, input logic exp_valid, input logic exp_new);
      @(posedge clk);
      #1;
      check({tag, ".out_valid"}, 64'(bus.out_valid), 64'(exp_valid));
      if (exp_new) begin
         if (sb.size() == 0) begin
            n_cmp++;
            n_err++;
            $error("FAIL %s.scoreboard observed=empty expected=entry", tag);
         end else begin
            cur = sb.pop_front();
         end
      end
      check_regs(tag);
      @(negedge clk);
   endtask

   initial begin
      cur   = '0;
      reset = 1'b0;
      idle();
      bus.out_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check("rst.out_valid", 64'(bus.out_valid), 64'd0);
      check("rst.in_ready",  64'(bus.in_ready),  64'd1);
      check_regs("rst");
      reset = 1'b1;

      // WB writes r5 with no instruction present
      bus.wb_wen = 1'b1; bus.wb_waddr = 5'd5; bus.wb_wdata = 32'h1234;
      tick("s1", 1'b0, 1'b0);
      idle();

      // rs=5 from regfile, rt=8 through same-cycle WB write
      drive_inst(32'h100, 5'd5, 5'd8, 16'h0010, 1'b0, 1'b0);
      bus.wb_wen = 1'b1; bus.wb_waddr = 5'd8; bus.wb_wdata = 32'hCAFE;
      expect_out(32'h100, 32'h1234, 32'hCAFE, 32'h10, 5'd8);
      #1;
      check("s2.in_ready", 64'(bus.in_ready), 64'd1);
      check("s2.jrpc",     64'(bus.jrpc),     64'h1234);
      check("s2.rs_eq_rt", 64'(bus.rs_eq_rt), 64'd0);
      tick("s2", 1'b1, 1'b1);
      idle();

      // EXE beats MEM on r3, sign-extended imm, dest = rd
      drive_inst(32'h104, 5'd3, 5'd3, 16'h8001, 1'b1, 1'b1);
      bus.exe_wen = 1'b1; bus.exe_wreg = 5'd3; bus.exe_wdata = 32'hAAAA;
      bus.mem_wen = 1'b1; bus.mem_wreg = 5'd3; bus.mem_wdata = 32'hBBBB;
      expect_out(32'h104, 32'hAAAA, 32'hAAAA, 32'hFFFF8001, 5'd16);
      #1;
      check("s3.jrpc",     64'(bus.jrpc),     64'hAAAA);
      check("s3.rs_eq_rt", 64'(bus.rs_eq_rt), 64'd1);
      tick("s3", 1'b1, 1'b1);
      idle();

      // MEM beats WB on r4, zero-extended imm
      drive_inst(32'h108, 5'd4, 5'd5, 16'h8001, 1'b0, 1'b0);
      bus.mem_wen = 1'b1; bus.mem_wreg = 5'd4; bus.mem_wdata = 32'h4444;
      bus.wb_wen  = 1'b1; bus.wb_waddr = 5'd4; bus.wb_wdata  = 32'h9999;
      expect_out(32'h108, 32'h4444, 32'h1234, 32'h00008001, 5'd5);
      #1;
      check("s4.jrpc",     64'(bus.jrpc),     64'h4444);
      check("s4.rs_eq_rt", 64'(bus.rs_eq_rt), 64'd0);
      tick("s4", 1'b1, 1'b1);
      idle();

      // load-use on rt=7: one stall cycle, bubble, then MEM forwards load data
      drive_inst(32'h10C, 5'd4, 5'd7, 16'h0000, 1'b0, 1'b1);
      bus.exe_wen = 1'b1; bus.exe_is_load = 1'b1; bus.exe_wreg = 5'd7; bus.exe_wdata = 32'hDEAD;
      #1;
      check("s5.in_ready", 64'(bus.in_ready), 64'd0);
      tick("s5", 1'b0, 1'b0);
      idle();
      drive_inst(32'h10C, 5'd4, 5'd7, 16'h0000, 1'b0, 1'b1);
      bus.mem_wen = 1'b1; bus.mem_wreg = 5'd7; bus.mem_wdata = 32'h55;
      expect_out(32'h10C, 32'h9999, 32'h55, 32'h0, 5'd0);
      #1;
      check("s6.in_ready", 64'(bus.in_ready), 64'd1);
      tick("s6", 1'b1, 1'b1);
      idle();

      // back-pressure from EXE for two cycles, outputs hold
      bus.out_ready = 1'b0;
      drive_inst(32'h110, 5'd5, 5'd0, 16'h0001, 1'b0, 1'b0);
      #1;
      check("s7a.in_ready", 64'(bus.in_ready), 64'd0);
      tick("s7a", 1'b1, 1'b0);
      #1;
      check("s7b.in_ready", 64'(bus.in_ready), 64'd0);
      tick("s7b", 1'b1, 1'b0);
      bus.out_ready = 1'b1;
      expect_out(32'h110, 32'h1234, 32'h0, 32'h1, 5'd0);
      #1;
      check("s8.in_ready", 64'(bus.in_ready), 64'd1);
      tick("s8", 1'b1, 1'b1);
      idle();

      // r0 stays zero despite writes and forwarding aimed at it
      drive_inst(32'h114, 5'd0, 5'd0, 16'h7FFF, 1'b1, 1'b1);
      bus.exe_wen = 1'b1; bus.exe_wreg = 5'd0; bus.exe_wdata = 32'hFFFF;
      bus.mem_wen = 1'b1; bus.mem_wreg = 5'd0; bus.mem_wdata = 32'hFFFF;
      bus.wb_wen  = 1'b1; bus.wb_waddr = 5'd0; bus.wb_wdata  = 32'hFFFF;
      expect_out(32'h114, 32'h0, 32'h0, 32'h00007FFF, 5'd15);
      #1;
      check("s9.jrpc",     64'(bus.jrpc),     64'h0);
      check("s9.rs_eq_rt", 64'(bus.rs_eq_rt), 64'd1);
      tick("s9", 1'b1, 1'b1);
      idle();
      drive_inst(32'h118, 5'd0, 5'd8, 16'hFFFF, 1'b0, 1'b0);
      expect_out(32'h118, 32'h0, 32'hCAFE, 32'h0000FFFF, 5'd8);
      tick("s10", 1'b1, 1'b1);
      idle();

      // flush overrides a load-use stall, drops the instruction, no count
      drive_inst(32'h11C, 5'd8, 5'd8, 16'h0000, 1'b0, 1'b0);
      bus.exe_wen = 1'b1; bus.exe_is_load = 1'b1; bus.exe_wreg = 5'd8;
      bus.flush = 1'b1;
      #1;
      check("s11.in_ready", 64'(bus.in_ready), 64'd1);
      tick("s11", 1'b0, 1'b0);
      idle();
      tick("s12", 1'b0, 1'b0);

      drive_inst(32'h120, 5'd5, 5'd4, 16'h0002, 1'b0, 1'b0);
      expect_out(32'h120, 32'h1234, 32'h9999, 32'h2, 5'd4);
      tick("s13", 1'b1, 1'b1);
      idle();

      // flush clears a held output even while EXE is not ready
      bus.out_ready = 1'b0;
      bus.flush = 1'b1;
      #1;
      check("s14.in_ready", 64'(bus.in_ready), 64'd1);
      tick("s14", 1'b0, 1'b0);
      idle();
      bus.out_ready = 1'b1;

`ifdef ID_STAGE_STALL_CNT_EN
      check("stall_cnt", 64'(stall_cnt), 64'd3);
`endif
      check("sb.remaining", 64'(sb.size()), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
